// File: rtl/adder_pkg.sv
// Shared definitions for the add/sub/compare datapath and its arbiter.
//   OP_*        : 2-bit operation encodings seen on reqN_op
//   WIDTH_DEF   : default operand/result width
//   rspState_t  : occupancy of the one-entry output register
//   isSubOp()   : adder runs in subtract mode for SUB and CMP
package adder_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_CMP = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;  // reserved, executes as ADD

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } rspState_t;

  function automatic logic isSubOp(input logic [1:0] op);
    return (op == OP_SUB) || (op == OP_CMP);
  endfunction

endpackage

// File: rtl/adder.sv
// Shared add/subtract unit.
//   a, b : operands
//   sub  : 1 = a-b, 0 = a+b (modulo 2^WIDTH, carry discarded)
//   sum  : result
module Adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum
);

  // Two's-complement subtract: invert b and inject the +1 as carry-in.
  assign sum = a + (sub ? ~b : b) + {{(WIDTH-1){1'b0}}, sub};

endmodule

// File: rtl/adder_arbiter_rr_arbiter2.sv
// Two-requester round-robin arbiter.
//   clk, rst_n : clock, synchronous active-low reset
//   req[1:0]   : request vector
//   enable     : grants may be issued this cycle
//   gnt[1:0]   : one-hot grant (all zero when disabled or idle)
// prio names the port that wins the next tie; it flips to the other port on
// every grant, so a lone requester also toggles it harmlessly.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       enable,
  output logic [1:0] gnt
);

  logic prio;

  always_comb begin
    gnt = 2'b00;
    if (enable) begin
      if (req == 2'b11) gnt = prio ? 2'b10 : 2'b01;
      else              gnt = req;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)    prio <= 1'b0;
    else if (|gnt) prio <= gnt[0];  // port 0 won -> port 1 next, and vice versa
  end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin sharing of one add/sub/compare datapath between two requesters.
//   clk, rst_n                      : clock, synchronous active-low reset
//   reqN_valid/op/a/b, reqN_ready   : requester N, handshake valid & ready
//   rsp_valid/id/result/gt/eq       : one-entry output register
//   rsp_ready                       : consumer takes the held result
//   flags_gt, flags_eq              : flags from the last accepted CMP
// The output register may drain and refill on the same edge, so a
// continuously ready consumer sees one result per cycle.
module adder_arbiter
  import adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_gt,
  output logic             rsp_eq,
  input  logic             rsp_ready,
  output logic             flags_gt,
  output logic             flags_eq
);

  rspState_t        state;
  logic             canAccept;
  logic [1:0]       gnt;
  logic             accept;
  logic             selId;
  logic [1:0]       selOp;
  logic [WIDTH-1:0] selA, selB, diff;
  logic             isCmp, cmpEq, cmpGt;

  assign rsp_valid = (state == FULL);
  assign canAccept = (state == EMPTY) || rsp_ready;

  // Gating with rst_n keeps both readies low during the reset cycle.
  rr_arbiter2 uArb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    ({req1_valid, req0_valid}),
    .enable (canAccept && rst_n),
    .gnt    (gnt)
  );

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];
  assign accept     = |gnt;

  // Operand mux is steered by the grant only; operands never reach ready.
  assign selId = gnt[1];
  assign selOp = selId ? req1_op : req0_op;
  assign selA  = selId ? req1_a  : req0_a;
  assign selB  = selId ? req1_b  : req0_b;

  Adder #(.WIDTH(WIDTH)) uAdder (
    .a   (selA),
    .b   (selB),
    .sub (isSubOp(selOp)),
    .sum (diff)
  );

  // Sign of the raw difference, no overflow correction.
  assign isCmp = (selOp == OP_CMP);
  assign cmpEq = (diff == '0);
  assign cmpGt = !diff[WIDTH-1] && !cmpEq;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= EMPTY;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_gt     <= 1'b0;
      rsp_eq     <= 1'b0;
      flags_gt   <= 1'b0;
      flags_eq   <= 1'b0;
    end else if (accept) begin
      state      <= FULL;
      rsp_id     <= selId;
      rsp_result <= diff;
      rsp_gt     <= isCmp && cmpGt;
      rsp_eq     <= isCmp && cmpEq;
      if (isCmp) begin
        flags_gt <= cmpGt;
        flags_eq <= cmpEq;
      end
    end else if (rsp_ready) begin
      // Drain only; data registers keep their stale contents.
      state <= EMPTY;
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
module tb_adder_arbiter;
  import adder_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req1_valid;
  logic [1:0]   req0_op, req1_op;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         req0_ready, req1_ready;
  logic         rsp_valid, rsp_id, rsp_gt, rsp_eq, rsp_ready;
  logic [W-1:0] rsp_result;
  logic         flags_gt, flags_eq;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  adder_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_gt(rsp_gt), .rsp_eq(rsp_eq),
    .rsp_ready(rsp_ready), .flags_gt(flags_gt), .flags_eq(flags_eq)
  );

  // ---------------- reference model ----------------
  // Held result plus "who wins the next tie"; arithmetic done with plain
  // +/- and a signed comparison of the difference.
  logic         mValid = 1'b0, mId = 1'b0, mGt = 1'b0, mEq = 1'b0;
  logic         mFgt = 1'b0, mFeq = 1'b0, mPrio = 1'b0;
  logic [W-1:0] mRes = '0;
  logic [1:0]   mGnt = 2'b00;
  logic [1:0]   mG;

  function automatic logic [1:0] refGrant(input logic rst, input logic held, input logic take,
                                          input logic v0, input logic v1, input logic tiePort);
    if (!rst) return 2'b00;
    if (held && !take) return 2'b00;
    if (v0 && v1) return tiePort ? 2'b10 : 2'b01;
    return {v1, v0};
  endfunction

  function automatic logic [W-1:0] refResult(input logic [1:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    if (op == OP_SUB || op == OP_CMP) return a - b;
    return a + b;
  endfunction

  function automatic logic refGt(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] d;
    d = a - b;
    return $signed(d) > 0;
  endfunction

  assign mG = refGrant(rst_n, mValid, rsp_ready, req0_valid, req1_valid, mPrio);

  always @(posedge clk) begin
    mGnt <= mG;
    if (!rst_n) begin
      mValid <= 1'b0; mId <= 1'b0; mRes <= '0; mGt <= 1'b0; mEq <= 1'b0;
      mFgt <= 1'b0; mFeq <= 1'b0; mPrio <= 1'b0;
    end else if (mG != 2'b00) begin
      mValid <= 1'b1;
      mId    <= mG[1];
      mPrio  <= mG[0];
      if (mG[1]) begin
        mRes <= refResult(req1_op, req1_a, req1_b);
        mGt  <= (req1_op == OP_CMP) && refGt(req1_a, req1_b);
        mEq  <= (req1_op == OP_CMP) && (req1_a == req1_b);
        if (req1_op == OP_CMP) begin mFgt <= refGt(req1_a, req1_b); mFeq <= (req1_a == req1_b); end
      end else begin
        mRes <= refResult(req0_op, req0_a, req0_b);
        mGt  <= (req0_op == OP_CMP) && refGt(req0_a, req0_b);
        mEq  <= (req0_op == OP_CMP) && (req0_a == req0_b);
        if (req0_op == OP_CMP) begin mFgt <= refGt(req0_a, req0_b); mFeq <= (req0_a == req0_b); end
      end
    end else if (rsp_ready) begin
      mValid <= 1'b0;
    end
  end

  // ---------------- stimulus helpers (no checking) ----------------
  // Outputs are sampled and inputs driven 1 time unit after the rising edge.
  task automatic clkWait();
    @(posedge clk); #1;
  endtask

  task automatic drive0(input logic v, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
  endtask

  task automatic drive1(input logic v, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; rsp_ready = 1'b1;
    drive0(1'b1, OP_ADD, 1, 1); drive1(1'b1, OP_ADD, 2, 2);
    #1;
    vectors++;
    if ({req1_ready, req0_ready} !== 2'b00) begin
      miscompares++; $display("FAIL reset_ready: got %b want 00", {req1_ready, req0_ready});
    end
    clkWait();
    vectors++;
    if ({rsp_valid, rsp_id, rsp_gt, rsp_eq, flags_gt, flags_eq, rsp_result} !== {6'b0, {W{1'b0}}}) begin
      miscompares++;
      $display("FAIL reset_outputs: got v%b id%b gt%b eq%b fg%b fe%b res %h want all 0",
               rsp_valid, rsp_id, rsp_gt, rsp_eq, flags_gt, flags_eq, rsp_result);
    end
    drive0(1'b0, OP_ADD, 0, 0); drive1(1'b0, OP_ADD, 0, 0);
    rst_n = 1'b1;
    clkWait();
  endtask

  task automatic test_single_add();
    rsp_ready = 1'b1;
    drive0(1'b1, OP_ADD, 5, 7);
    #1;
    vectors++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      miscompares++; $display("FAIL add_ready: got %b want 01", {req1_ready, req0_ready});
    end
    clkWait();
    drive0(1'b0, OP_ADD, 0, 0);
    vectors++;
    if ({rsp_valid, rsp_id, rsp_gt, rsp_eq, flags_gt, flags_eq} !== 6'b100000 || rsp_result !== 32'd12) begin
      miscompares++;
      $display("FAIL single_add: got v%b id%b gt%b eq%b fg%b fe%b res %0d want v1 id0 res 12 rest 0",
               rsp_valid, rsp_id, rsp_gt, rsp_eq, flags_gt, flags_eq, rsp_result);
    end
  endtask

  task automatic test_cmp();
    rsp_ready = 1'b1;
    drive1(1'b1, OP_CMP, 9, 3);
    #1;
    vectors++;
    if ({req1_ready, req0_ready} !== 2'b10) begin
      miscompares++; $display("FAIL cmp_ready: got %b want 10", {req1_ready, req0_ready});
    end
    clkWait();
    vectors++;
    if ({rsp_valid, rsp_id, rsp_gt, rsp_eq, flags_gt, flags_eq} !== 6'b111010 || rsp_result !== 32'd6) begin
      miscompares++;
      $display("FAIL cmp_gt: got v%b id%b gt%b eq%b fg%b fe%b res %0d want 111010 res 6",
               rsp_valid, rsp_id, rsp_gt, rsp_eq, flags_gt, flags_eq, rsp_result);
    end
    drive1(1'b1, OP_CMP, 4, 4);
    clkWait();
    vectors++;
    if ({rsp_valid, rsp_id, rsp_gt, rsp_eq, flags_gt, flags_eq} !== 6'b110101 || rsp_result !== 32'd0) begin
      miscompares++;
      $display("FAIL cmp_eq: got v%b id%b gt%b eq%b fg%b fe%b res %0d want 110101 res 0",
               rsp_valid, rsp_id, rsp_gt, rsp_eq, flags_gt, flags_eq, rsp_result);
    end
    drive1(1'b1, OP_SUB, 1, 2);
    clkWait();
    drive1(1'b0, OP_ADD, 0, 0);
    vectors++;
    if ({rsp_valid, rsp_id, rsp_gt, rsp_eq, flags_gt, flags_eq} !== 6'b110001 || rsp_result !== 32'hFFFF_FFFF) begin
      miscompares++;
      $display("FAIL sub_neg: got v%b id%b gt%b eq%b fg%b fe%b res %h want 110001 res ffffffff",
               rsp_valid, rsp_id, rsp_gt, rsp_eq, flags_gt, flags_eq, rsp_result);
    end
  endtask

  task automatic test_contention();
    logic [1:0] wantG;
    rst_n = 1'b0; clkWait(); rst_n = 1'b1;
    rsp_ready = 1'b1;
    drive0(1'b1, OP_ADD, 10, 20);
    drive1(1'b1, OP_SUB, 100, 1);
    for (int i = 0; i < 4; i++) begin
      wantG = (i % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      vectors++;
      if ({req1_ready, req0_ready} !== wantG) begin
        miscompares++; $display("FAIL contention_gnt[%0d]: got %b want %b", i, {req1_ready, req0_ready}, wantG);
      end
      clkWait();
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_id !== wantG[1] || rsp_result !== (wantG[1] ? 32'd99 : 32'd30)) begin
        miscompares++;
        $display("FAIL contention_rsp[%0d]: got v%b id%b res %0d want v1 id%b", i, rsp_valid, rsp_id, rsp_result, wantG[1]);
      end
    end
    drive1(1'b0, OP_ADD, 0, 0);
  endtask

  task automatic test_backpressure();
    // Held result from contention: port 1, 100-1.
    rsp_ready = 1'b0;
    drive0(1'b1, OP_ADD, 10, 20);
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if ({req1_ready, req0_ready} !== 2'b00) begin
        miscompares++; $display("FAIL bp_ready[%0d]: got %b want 00", i, {req1_ready, req0_ready});
      end
      clkWait();
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_result !== 32'd99) begin
        miscompares++; $display("FAIL bp_hold[%0d]: got v%b id%b res %0d want v1 id1 res 99", i, rsp_valid, rsp_id, rsp_result);
      end
    end
    rsp_ready = 1'b1;
    #1;
    vectors++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      miscompares++; $display("FAIL bp_refill_ready: got %b want 01", {req1_ready, req0_ready});
    end
    clkWait();
    drive0(1'b0, OP_ADD, 0, 0);
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 32'd30) begin
      miscompares++; $display("FAIL bp_refill: got v%b id%b res %0d want v1 id0 res 30", rsp_valid, rsp_id, rsp_result);
    end
  endtask

  task automatic test_wrap();
    rsp_ready = 1'b1;
    drive0(1'b1, OP_ADD, 32'hFFFF_FFFF, 32'd1);
    clkWait();
    drive0(1'b0, OP_ADD, 0, 0);
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_result !== 32'd0 || rsp_gt !== 1'b0 || rsp_eq !== 1'b0) begin
      miscompares++; $display("FAIL wrap: got v%b res %h gt%b eq%b want v1 res 0 gt0 eq0", rsp_valid, rsp_result, rsp_gt, rsp_eq);
    end
  endtask

  task automatic test_reset_mid();
    // Leave a CMP in the flags so clearing is observable, then hold it FULL.
    rsp_ready = 1'b1;
    drive1(1'b1, OP_CMP, 8, 2);
    clkWait();
    rsp_ready = 1'b0;
    drive0(1'b1, OP_ADD, 3, 4);
    drive1(1'b1, OP_SUB, 9, 4);
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({req1_ready, req0_ready} !== 2'b00) begin
      miscompares++; $display("FAIL rstmid_ready: got %b want 00", {req1_ready, req0_ready});
    end
    clkWait();
    vectors++;
    if ({rsp_valid, rsp_id, rsp_gt, rsp_eq, flags_gt, flags_eq, rsp_result} !== {6'b0, {W{1'b0}}}) begin
      miscompares++;
      $display("FAIL rstmid_outputs: got v%b id%b gt%b eq%b fg%b fe%b res %h want all 0",
               rsp_valid, rsp_id, rsp_gt, rsp_eq, flags_gt, flags_eq, rsp_result);
    end
    rst_n = 1'b1; rsp_ready = 1'b1;
    #1;
    vectors++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      miscompares++; $display("FAIL rstmid_tie: got %b want 01", {req1_ready, req0_ready});
    end
    clkWait();
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 32'd7) begin
      miscompares++; $display("FAIL rstmid_first: got v%b id%b res %0d want v1 id0 res 7", rsp_valid, rsp_id, rsp_result);
    end
    drive0(1'b0, OP_ADD, 0, 0);
    clkWait();  // port 1 still pending, wins now
    drive1(1'b0, OP_ADD, 0, 0);
    vectors++;
    if (rsp_id !== 1'b1 || rsp_result !== 32'd5) begin
      miscompares++; $display("FAIL rstmid_second: got id%b res %0d want id1 res 5", rsp_id, rsp_result);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    for (int n = 0; n < 400; n++) begin
      // Outputs after the previous edge versus the model.
      vectors++;
      if ({rsp_valid, rsp_id, rsp_gt, rsp_eq, flags_gt, flags_eq} !== {mValid, mId, mGt, mEq, mFgt, mFeq}) begin
        miscompares++;
        $display("FAIL rand_flags[%0d]: got v%b id%b gt%b eq%b fg%b fe%b want v%b id%b gt%b eq%b fg%b fe%b", n,
                 rsp_valid, rsp_id, rsp_gt, rsp_eq, flags_gt, flags_eq, mValid, mId, mGt, mEq, mFgt, mFeq);
      end
      vectors++;
      if (rsp_result !== mRes) begin
        miscompares++; $display("FAIL rand_result[%0d]: got %h want %h", n, rsp_result, mRes);
      end
      // New stimulus; a pending, ungranted request is held unchanged.
      rst_n = ($urandom_range(0, 49) != 0);
      rsp_ready = ($urandom_range(0, 9) < 7);
      if (!(req0_valid && !mGnt[0])) begin
        a = ($urandom_range(0, 1) != 0) ? W'($urandom_range(0, 7)) : W'($urandom);
        b = ($urandom_range(0, 1) != 0) ? W'($urandom_range(0, 7)) : W'($urandom);
        drive0($urandom_range(0, 9) < 6, 2'($urandom_range(0, 3)), a, b);
      end
      if (!(req1_valid && !mGnt[1])) begin
        a = ($urandom_range(0, 1) != 0) ? W'($urandom_range(0, 7)) : W'($urandom);
        b = ($urandom_range(0, 1) != 0) ? W'($urandom_range(0, 7)) : W'($urandom);
        drive1($urandom_range(0, 9) < 6, 2'($urandom_range(0, 3)), a, b);
      end
      #1;
      vectors++;
      if ({req1_ready, req0_ready} !== mG) begin
        miscompares++; $display("FAIL rand_grant[%0d]: got %b want %b", n, {req1_ready, req0_ready}, mG);
      end
      clkWait();
    end
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; rsp_ready = 1'b0;
    drive0(1'b0, OP_ADD, 0, 0); drive1(1'b0, OP_ADD, 0, 0);
    clkWait();
    test_reset();
    test_single_add();
    test_cmp();
    test_contention();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
